// File: rtl/smss_sbox_seq.sv
// rtl/smss_sbox_seq.sv - sequenced SMSS power-19 S-box, one shared GF(2^3) multiplier over three cycles.
// Define SMSS_SBOX_FAST_EN for the single-cycle variant with three multipliers.
module smss_sbox_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_data,
  output logic       busy
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MUL0 = 3'd1;
  localparam logic [2:0] MUL1 = 3'd2;
  localparam logic [2:0] MUL2 = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] c;
    c[0] = (a[0] & b[0]) ^ (a[1] & b[2]) ^ (a[2] & b[1]) ^ (a[2] & b[2]);
    c[1] = (a[0] & b[1]) ^ (a[1] & b[0]) ^ (a[2] & b[2]);
    c[2] = (a[2] & b[0]) ^ (a[1] & b[1]) ^ (a[0] & b[2]) ^ (a[1] & b[2])
         ^ (a[2] & b[1]) ^ (a[2] & b[2]);
    return c;
  endfunction

  function automatic logic [2:0] gf_sq(input logic [2:0] a);
    return {a[1] ^ a[2], a[2], a[0] ^ a[2]};
  endfunction

  function automatic logic [2:0] gf_four(input logic [2:0] a);
    return {a[1], a[1] ^ a[2], a[0] ^ a[1]};
  endfunction

  function automatic logic [5:0] iso(input logic [5:0] x);
    logic [5:0] z;
    z[0] = x[0] ^ x[2] ^ x[4] ^ x[5];
    z[1] = x[1] ^ x[4];
    z[2] = x[2] ^ x[4];
    z[3] = x[0] ^ x[1];
    z[4] = x[1] ^ x[3];
    z[5] = x[1] ^ x[4] ^ x[5];
    return z;
  endfunction

  function automatic logic [5:0] inv_iso(input logic [5:0] w);
    logic [5:0] p;
    p[0] = w[0] ^ w[1] ^ w[2] ^ w[3] ^ w[5];
    p[1] = w[0] ^ w[2];
    p[2] = w[1] ^ w[3] ^ w[4];
    p[3] = w[1] ^ w[4] ^ w[5];
    p[4] = w[1];
    p[5] = w[5];
    return p;
  endfunction

  logic [2:0] state_q, state_d;
  logic [5:0] out_q, out_d;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_q;

`ifdef SMSS_SBOX_FAST_EN
  // Whole power-19 chain evaluated straight from the operand in the accept cycle.
  logic [5:0] f_z;
  logic [2:0] f_lo, f_hi, f_u;
  logic [5:0] f_y;

  always_comb begin
    f_z  = iso(in_data);
    f_lo = f_z[2:0];
    f_hi = f_z[5:3];
    f_u  = gf_sq(gf_mul(f_lo, f_hi)) ^ gf_four(f_lo ^ f_hi);
    f_y  = inv_iso({gf_mul(f_hi, f_u), gf_mul(f_lo, f_u)}) ^ {6{in_data[2] ^ in_data[4]}};
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          out_d   = f_y;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= 6'h00;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end
`else
  logic [5:0] z_q, z_d;
  logic       tmask_q, tmask_d;
  logic [2:0] u_q, u_d;
  logic [2:0] wlo_q, wlo_d;
  logic [2:0] lo, hi;
  logic [2:0] mul_a, mul_b, mul_c;

  assign lo = z_q[2:0];
  assign hi = z_q[5:3];

  // The only multiplier: operands steered by the current step of the schedule.
  always_comb begin
    mul_a = lo;
    mul_b = hi;
    case (state_q)
      MUL1: begin
        mul_a = lo;
        mul_b = u_q;
      end
      MUL2: begin
        mul_a = hi;
        mul_b = u_q;
      end
      default: ;
    endcase
  end

  assign mul_c = gf_mul(mul_a, mul_b);

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    tmask_d = tmask_q;
    u_d     = u_q;
    wlo_d   = wlo_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          z_d     = iso(in_data);
          tmask_d = in_data[2] ^ in_data[4];
          state_d = MUL0;
        end
      end
      MUL0: begin
        u_d     = gf_sq(mul_c) ^ gf_four(lo ^ hi);
        state_d = MUL1;
      end
      MUL1: begin
        wlo_d   = mul_c;
        state_d = MUL2;
      end
      MUL2: begin
        out_d   = inv_iso({mul_c, wlo_q}) ^ {6{tmask_q}};
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      z_q     <= 6'h00;
      tmask_q <= 1'b0;
      u_q     <= 3'h0;
      wlo_q   <= 3'h0;
      out_q   <= 6'h00;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      tmask_q <= tmask_d;
      u_q     <= u_d;
      wlo_q   <= wlo_d;
      out_q   <= out_d;
    end
  end
`endif

endmodule

// File: tb/tb_smss_sbox_seq.sv
// tb/tb_smss_sbox_seq.sv - self-checking bench for smss_sbox_seq against a reference S-box model.
module tb_smss_sbox_seq;

`ifdef SMSS_SBOX_FAST_EN
  localparam int LAT = 1;
  localparam int II  = 2;
`else
  localparam int LAT = 4;
  localparam int II  = 5;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  smss_sbox_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: power-19 map in the z basis, operating on 3-bit field elements.
  function automatic logic [2:0] r_mul(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] c;
    c[0] = a[0]&b[0] ^ a[1]&b[2] ^ a[2]&b[1] ^ a[2]&b[2];
    c[1] = a[0]&b[1] ^ a[1]&b[0] ^ a[2]&b[2];
    c[2] = a[2]&b[0] ^ a[1]&b[1] ^ a[0]&b[2] ^ a[1]&b[2] ^ a[2]&b[1] ^ a[2]&b[2];
    return c;
  endfunction

  function automatic logic [5:0] ref_f(input logic [5:0] x);
    logic [5:0] z, w, p;
    logic [2:0] lo, hi, m, s, d, f, u;
    z  = {x[1]^x[4]^x[5], x[1]^x[3], x[0]^x[1], x[2]^x[4], x[1]^x[4], x[0]^x[2]^x[4]^x[5]};
    lo = z[2:0];
    hi = z[5:3];
    m  = r_mul(lo, hi);
    s  = {m[1]^m[2], m[2], m[0]^m[2]};
    d  = lo ^ hi;
    f  = {d[1], d[1]^d[2], d[0]^d[1]};
    u  = s ^ f;
    w  = {r_mul(hi, u), r_mul(lo, u)};
    p  = {w[5], w[1], w[1]^w[4]^w[5], w[1]^w[3]^w[4], w[0]^w[2], w[0]^w[1]^w[2]^w[3]^w[5]};
    return p ^ {6{x[2]^x[4]}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept x with out_ready high, measure latency, check result and handshake.
  task automatic run_op(input logic [5:0] x, input logic [5:0] exp_const, input string tag);
    int lat;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(1'b1));
    in_data   = x;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = 6'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(LAT));
    chk({tag, "_const"}, 32'(out_data), 32'(exp_const));
    chk({tag, "_model"}, 32'(out_data), 32'(ref_f(x)));
    tick();
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'(1'b0));
    chk({tag, "_ready_rise"}, 32'(in_ready), 32'(1'b1));
  endtask

  int order[64];
  logic [5:0] exp_q[$];

  initial begin
    int j, tmp, k, nrecv, cyc, last_acc, w;
    logic acc, del;
    logic [5:0] got, e;

    rst = 1'b1; in_valid = 1'b0; in_data = 6'h00; out_ready = 1'b0;
    tick();
    tick();
    chk("reset_in_ready", 32'(in_ready), 32'(1'b1));
    chk("reset_out_valid", 32'(out_valid), 32'(1'b0));
    chk("reset_out_data", 32'(out_data), 32'(6'h00));
    chk("reset_busy", 32'(busy), 32'(1'b0));
    rst = 1'b0;
    tick();

    // Reset during the operation's second step.
    in_data = 6'h2d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("accept_busy", 32'(busy), 32'(1'b1));
    chk("accept_in_ready", 32'(in_ready), 32'(1'b0));
    if (LAT > 1) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'(1'b1));
    chk("midrst_out_valid", 32'(out_valid), 32'(1'b0));
    chk("midrst_out_data", 32'(out_data), 32'(6'h00));
    chk("midrst_busy", 32'(busy), 32'(1'b0));
    tick();

    run_op(6'h00, 6'h00, "x00");
    run_op(6'h01, 6'h06, "x01");
    run_op(6'h04, 6'h22, "x04");

    // Backpressure with stray in_valid pulses.
    in_data = 6'h04; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    w = 1;
    while (!out_valid && w < 50) begin
      tick();
      w++;
    end
    chk("bp_latency", 32'(w), 32'(LAT));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = 6'($urandom);
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'(1'b1));
      chk("bp_out_data", 32'(out_data), 32'(6'h22));
      chk("bp_in_ready", 32'(in_ready), 32'(1'b0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(out_valid), 32'(1'b0));
    chk("bp_release_busy", 32'(busy), 32'(1'b0));
    tick();
    chk("bp_no_stray_accept", 32'(busy), 32'(1'b0));

    // All 64 operands in shuffled order, back-to-back, random consumer stalls.
    for (int i = 0; i < 64; i++) order[i] = i;
    for (int i = 63; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    k = 0; nrecv = 0; cyc = 0; last_acc = -1;
    exp_q.delete();
    while (nrecv < 64 && cyc < 4000) begin
      if (k < 64) begin
        in_valid = 1'b1;
        in_data  = order[k][5:0];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      got = out_data;
      tick();
      cyc++;
      if (acc) begin
        if (last_acc >= 0) chk("stream_interval_ok", 32'(cyc - last_acc >= II), 32'(1));
        last_acc = cyc;
        exp_q.push_back(ref_f(in_data));
        k++;
      end
      if (del) begin
        if (exp_q.size() == 0) begin
          chk("stream_unexpected_output", 32'(got), 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          chk("stream_data", 32'(got), 32'(e));
        end
        nrecv++;
      end
    end
    chk("stream_accepted", 32'(k), 32'(64));
    chk("stream_delivered", 32'(nrecv), 32'(64));
    chk("stream_pending", 32'(exp_q.size()), 32'(0));
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();

    // Reset while a result is held in DONE.
    in_data = 6'($urandom); in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    w = 1;
    while (!out_valid && w < 50) begin
      tick();
      w++;
    end
    chk("donerst_reached", 32'(out_valid), 32'(1'b1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("donerst_out_valid", 32'(out_valid), 32'(1'b0));
    chk("donerst_out_data", 32'(out_data), 32'(6'h00));
    chk("donerst_busy", 32'(busy), 32'(1'b0));
    run_op(6'h01, 6'h06, "after_rst_x01");

    // Reset and in_valid together: nothing captured.
    in_data = 6'h15; in_valid = 1'b1; rst = 1'b1;
    tick();
    in_valid = 1'b0; rst = 1'b0;
    chk("rst_vs_valid_busy", 32'(busy), 32'(1'b0));
    tick();
    chk("rst_vs_valid_idle", 32'(busy), 32'(1'b0));
    chk("rst_vs_valid_no_out", 32'(out_valid), 32'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
